// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready stream interface.
// Define PIPELINED_CLA_SAT_EN to saturate the sum on signed overflow.
module pipelined_cla_adder #(
  parameter int N      = 32,
  parameter int G      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         of
);

  localparam int NG  = N / G;
  localparam int GPS = NG / STAGES;

  logic [N-1:0] a_q [STAGES];
  logic [N-1:0] a_d [STAGES];
  logic [N-1:0] b_q [STAGES];
  logic [N-1:0] b_d [STAGES];
  logic [N-1:0] s_q [STAGES];
  logic [N-1:0] s_d [STAGES];
  logic         c_q [STAGES];
  logic         c_d [STAGES];
  logic         v_q [STAGES];
  logic         v_d [STAGES];
  logic         of_q;
  logic         of_d;

  logic [N-1:0] src_a [STAGES];
  logic [N-1:0] src_b [STAGES];
  logic [N-1:0] src_s [STAGES];
  logic         src_c [STAGES];
  logic         src_v [STAGES];

  logic adv;

  // One lookahead group: every internal carry is a flat sum of products of
  // the group's generate/propagate terms and the incoming group carry.
  function automatic logic [G:0] cla_group(input logic [G-1:0] a,
                                           input logic [G-1:0] b,
                                           input logic ci);
    logic [G-1:0] p;
    logic [G-1:0] g;
    logic [G:0]   c;
    logic         term;
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = ci;
    for (int j = 1; j <= G; j++) begin
      term = ci;
      for (int m = 0; m < j; m++) term = term & p[m];
      c[j] = term;
      for (int i = 0; i < j; i++) begin
        term = g[i];
        for (int m = i + 1; m < j; m++) term = term & p[m];
        c[j] = c[j] | term;
      end
    end
    return {c[G], p ^ c[G-1:0]};
  endfunction

  assign adv      = out_ready | ~v_q[STAGES-1];
  assign in_ready = adv;

  always_comb begin
    logic [N-1:0] seg_s;
    logic         carry;
    logic [G:0]   grp;
    int           idx;
    logic         sa;
    logic         sb;
    logic         ovf;

    src_a = '{default: '0};
    src_b = '{default: '0};
    src_s = '{default: '0};
    src_c = '{default: 1'b0};
    src_v = '{default: 1'b0};
    a_d   = '{default: '0};
    b_d   = '{default: '0};
    s_d   = '{default: '0};
    c_d   = '{default: 1'b0};
    v_d   = '{default: 1'b0};
    of_d  = of_q;
    seg_s = '0;
    carry = 1'b0;
    grp   = '0;
    idx   = 0;
    sa    = 1'b0;
    sb    = 1'b0;
    ovf   = 1'b0;

    // Subtraction is A + ~B + 1; cin only matters for addition.
    src_a[0] = in1;
    src_b[0] = sub ? ~in2 : in2;
    src_c[0] = sub | cin;
    src_s[0] = '0;
    src_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
      src_v[k] = v_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      seg_s = src_s[k];
      carry = src_c[k];
      for (int gi = 0; gi < GPS; gi++) begin
        idx            = (k * GPS + gi) * G;
        grp            = cla_group(src_a[k][idx +: G], src_b[k][idx +: G], carry);
        seg_s[idx +: G] = grp[G-1:0];
        carry          = grp[G];
      end

      if (k == STAGES - 1) begin
        sa  = src_a[k][N-1];
        sb  = src_b[k][N-1];
        ovf = (sa == sb) & (seg_s[N-1] != sa);
`ifdef PIPELINED_CLA_SAT_EN
        if (ovf) seg_s = sa ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
        if (adv) of_d = ovf;
      end

      // A stall freezes every stage, bubbles included.
      a_d[k] = adv ? src_a[k] : a_q[k];
      b_d[k] = adv ? src_b[k] : b_q[k];
      s_d[k] = adv ? seg_s    : s_q[k];
      c_d[k] = adv ? carry    : c_q[k];
      v_d[k] = adv ? src_v[k] : v_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      of_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
      of_q <= of_d;
    end
  end

  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign of        = of_q;
  assign out_valid = v_q[STAGES-1];

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready stream interface.
- Operand width, lookahead group size and pipeline depth are all parameters.
- Adds carry-in, a subtract mode, signed overflow and backpressure, so wide adders close timing by splitting the carry chain across register stages.
- Sits in the datapath between operand-select logic and the ALU result mux.

Parameters:
N, 32, operand/result width in bits; must be a multiple of G.
G, 4, lookahead group width in bits; each group computes its generate/propagate terms and carries in parallel, and groups ripple group-carry.
STAGES, 2, number of pipeline register stages (>=1); (N/G) must be divisible by STAGES.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands present
in_ready  out  1  block can accept operands this cycle
in1  in  N  operand A
in2  in  N  operand B
cin  in  1  carry-in, used in add mode only
sub  in  1  1 = A - B, 0 = A + B + cin
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
sum  out  N  result
cout  out  1  carry-out (add); no-borrow flag (sub, 1 = A >= B unsigned)
of  out  1  two's-complement signed overflow

Behaviour:
- Reset: all stage valid bits, out_valid, sum, cout and of are cleared to 0 asynchronously while rst_n=0. in_ready=1 once reset is released.
- Operand conditioning, applied on the input side:
  - Effective B = sub ? ~in2 : in2.
  - Effective carry-in = sub ? 1 : cin; cin is ignored when sub=1.
- Carry chain and staging:
  - The chain is split into STAGES segments of (N/G)/STAGES groups each.
  - Stage k resolves its segment's sum bits from the carry registered by stage k-1.
  - Stage k forwards, as registered payload: the partial sum, the segment carry-out, the remaining unprocessed operand slices, and the operand sign bits.
- Latency: exactly STAGES cycles from an accepted input (in_valid & in_ready) to out_valid, when there is no stall.
- Handshake:
  - Global advance enable adv = out_ready | ~out_valid.
  - in_ready = adv; this is combinational from out_ready.
  - On adv, every stage loads from its predecessor, and stage 0 loads the input with valid = in_valid.
  - When adv=0, all stages hold their contents.
  - Throughput is one result per cycle while out_ready=1.
  - Transfers are strictly in order; no drop and no duplication.
- Output stability: while out_valid=1 and out_ready=0, sum, cout and of are held stable.
- Bubbles: an empty stage (valid=0) may load even when a downstream stage is stalled only if adv=1; there is no bubble collapsing. This keeps the implementation simple.
- Overflow:
  - of = (A[N-1] == Beff[N-1]) & (sum[N-1] != A[N-1]), where Beff is effective B.
  - Computed in the final stage from the registered sign bits.
- cout is the carry out of bit N-1 of the full A + Beff + carry-in.
- Simultaneous events:
  - New input accepted in the same cycle the last result is consumed: both occur.
  - rst_n asserted mid-flight: all in-flight operations are discarded and out_valid drops immediately.
- When out_valid=0, the values on sum/cout/of are don't-care, but must be reset-clean (0) after reset.

Optional Feature:
- Macro: PIPELINED_CLA_SAT_EN.
- Defined:
  - sum saturates on signed overflow: of=1 with A[N-1]=0 gives sum = 2^(N-1)-1; of=1 with A[N-1]=1 gives sum = 2^(N-1).
  - of still reports the overflow.
  - cout is unaffected.
  - Latency is unchanged (clamp logic sits in the final stage).
- Not defined: sum wraps modulo 2^N. No clamp logic is present.

Test Plan:
- N=32, STAGES=2, add, in1=0x7FFFFFFF, in2=0x00000001, cin=0 -> 2 cycles later sum=0x80000000, of=1, cout=0 (SAT_EN: sum=0x7FFFFFFF, of=1).
- Add, in1=0xFFFFFFFF, in2=0x00000001, cin=0 -> sum=0x00000000, cout=1, of=0; then in1=0x0000000F, in2=0x00000001, cin=1 -> sum=0x00000011, cout=0.
- sub=1, in1=5, in2=7, cin=1 -> sum=0xFFFFFFFE, cout=0, of=0; sub=1, in1=0x80000000, in2=1 -> sum=0x7FFFFFFF, of=1, cout=1.
- Stream of 10 random pairs with in_valid=1 every cycle, out_ready held 0 for cycles 3-5 -> in_ready=0 during the stall, outputs held stable, all 10 results in order and matching the reference model, no gaps once out_ready=1.
- Two operations in flight, rst_n pulsed low for 1 cycle -> out_valid=0 immediately, and no stale result emerges afterwards; a new op after reset returns after exactly STAGES cycles.
- Repeat the random stream for (N,G,STAGES) = (16,4,1), (64,8,4), (32,4,8) -> results match A+B+cin / A-B, and cout/of are correct at every width.
